// File: rtl/jp.sv
// rtl/jp.sv - NES joypad controller: pad poller plus 0x4016/0x4017 strobe-and-shift ports (pad 2 under JP_PAD2_EN)
module jp #(
    parameter int CLK_DIV     = 300,
    parameter int POLL_CYCLES = 833333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        jp_data1_in,
    input  logic        jp_data2_in,
    output logic        jp_latch,
    output logic        jp_clk
);

    localparam int PW = $clog2(POLL_CYCLES);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
    localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_LATCH,
        S_GAP,
        S_PULSE_HI,
        S_PULSE_LO,
        S_DONE
    } poll_state_t;

    poll_state_t   state, state_nxt;
    logic [PW-1:0] poll_cnt;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] phase_last;
    logic          phase_end;
    logic          capture;
    logic [2:0]    bit_cnt;

    logic [1:0]    sync1;
    logic          pad1;
    logic [7:0]    cap1, state1, shift1;

    logic          strobe;
    logic          hit1, rd1, rd1_q, wr_strobe, reload;
    logic          unused_din;

    assign unused_din = ^din[7:1];
    assign pad1       = ~sync1[1];

    always_comb begin
        state_nxt  = state;
        phase_last = DIV_LAST;
        if (state == S_LATCH)
            phase_last = LATCH_LAST;
        phase_end = (div_cnt == phase_last);
        capture   = phase_end && (state == S_GAP || state == S_PULSE_LO);
        case (state)
            S_WAIT:     if (poll_cnt == POLL_LAST) state_nxt = S_LATCH;
            S_LATCH:    if (phase_end) state_nxt = S_GAP;
            S_GAP:      if (phase_end) state_nxt = S_PULSE_HI;
            S_PULSE_HI: if (phase_end) state_nxt = S_PULSE_LO;
            S_PULSE_LO: if (phase_end) state_nxt = (bit_cnt == 3'd7) ? S_DONE : S_PULSE_HI;
            S_DONE:     state_nxt = S_WAIT;
            default:    state_nxt = S_WAIT;
        endcase
    end

    // Poll counter is free-running so poll starts stay exactly POLL_CYCLES apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_WAIT;
            poll_cnt <= POLL_LAST;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            jp_latch <= 1'b0;
            jp_clk   <= 1'b0;
        end else begin
            state    <= state_nxt;
            poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
            div_cnt  <= (state == S_WAIT || state_nxt != state) ? '0 : div_cnt + 1'b1;
            jp_latch <= (state_nxt == S_LATCH);
            jp_clk   <= (state_nxt == S_PULSE_HI);
            if (capture)
                bit_cnt <= (state == S_GAP) ? 3'd1 : bit_cnt + 3'd1;
        end
    end

    // Captured bits shift in from the top, so after eight captures A lands in bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 2'b11;
            cap1  <= 8'h00;
        end else begin
            sync1 <= {sync1[0], jp_data1_in};
            if (capture)
                cap1 <= {pad1, cap1[7:1]};
        end
    end

    assign hit1      = (addr == 16'h4016);
    assign rd1       = !wr && hit1;
    assign wr_strobe = wr && hit1;
    assign reload    = strobe || (wr_strobe && din[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= 1'b0;
            state1 <= 8'h00;
            shift1 <= 8'h00;
            rd1_q  <= 1'b0;
        end else begin
            rd1_q <= rd1;
            if (wr_strobe)
                strobe <= din[0];
            if (state == S_DONE)
                state1 <= cap1;
            if (reload)
                shift1 <= state1;
            else if (rd1_q && !rd1)
                shift1 <= {1'b1, shift1[7:1]};
        end
    end

`ifdef JP_PAD2_EN
    logic [1:0] sync2;
    logic       pad2;
    logic [7:0] cap2, state2, shift2;
    logic       rd2, rd2_q;

    assign pad2 = ~sync2[1];
    assign rd2  = !wr && (addr == 16'h4017);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync2  <= 2'b11;
            cap2   <= 8'h00;
            state2 <= 8'h00;
            shift2 <= 8'h00;
            rd2_q  <= 1'b0;
        end else begin
            sync2 <= {sync2[0], jp_data2_in};
            rd2_q <= rd2;
            if (capture)
                cap2 <= {pad2, cap2[7:1]};
            if (state == S_DONE)
                state2 <= cap2;
            if (reload)
                shift2 <= state2;
            else if (rd2_q && !rd2)
                shift2 <= {1'b1, shift2[7:1]};
        end
    end

    always_comb begin
        dout = 8'h00;
        if (rd1)
            dout = {7'b0, shift1[0]};
        else if (rd2)
            dout = {7'b0, shift2[0]};
    end
`else
    logic unused_pad2;
    assign unused_pad2 = jp_data2_in;

    always_comb begin
        dout = 8'h00;
        if (rd1)
            dout = {7'b0, shift1[0]};
    end
`endif

endmodule

// File: tb/tb_jp.sv
// tb/tb_jp.sv - self-checking bench for jp with a serial pad model and read scoreboard
module tb_jp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        jp_data1_in, jp_data2_in;
    logic        jp_latch, jp_clk;

    logic [7:0]  btn1 = 8'h09;
    logic [7:0]  btn2 = 8'h80;
    logic [7:0]  sr1 = 8'hFF;
    logic [7:0]  sr2 = 8'hFF;

    int          total = 0;
    int          bad = 0;
    logic        mon_en = 1'b0;
    logic [7:0]  exp_q[$];
    string       tag_q[$];

    jp #(.CLK_DIV(4), .POLL_CYCLES(200)) dut (
        .clk(clk), .rst(rst), .wr(wr), .addr(addr), .din(din), .dout(dout),
        .jp_data1_in(jp_data1_in), .jp_data2_in(jp_data2_in),
        .jp_latch(jp_latch), .jp_clk(jp_clk)
    );

    always #5 clk = ~clk;

    // 4021-style pad: parallel load while latched, shift on each rising pad clock.
    always @(posedge jp_latch or posedge jp_clk) begin
        if (jp_latch) begin
            sr1 <= ~btn1;
            sr2 <= ~btn2;
        end else begin
            sr1 <= {1'b1, sr1[7:1]};
            sr2 <= {1'b1, sr2[7:1]};
        end
    end
    assign jp_data1_in = sr1[0];
    assign jp_data2_in = sr2[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0)
                check("sb_underflow", 32'd1, 32'd0);
            else
                check(tag_q.pop_front(), {24'h0, dout}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        wr = 1'b0; addr = 16'h0000; din = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input int n, input string tag);
        @(posedge clk); #1;
        wr = 1'b0; addr = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        mon_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        addr = 16'h0000; mon_en = 1'b0;
    endtask

    task automatic measure_poll(output int width, output int pulses, output int period);
        logic prev_l, prev_c;
        width = 1; pulses = 0; period = 0;
        prev_l = 1'b1; prev_c = jp_clk;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            period++;
            if (jp_latch && !prev_l) break;
            if (jp_latch) width++;
            if (jp_clk && !prev_c) pulses++;
            prev_l = jp_latch;
            prev_c = jp_clk;
        end
    endtask

    task automatic wait_poll();
        logic prev, found;
        found = 1'b0;
        prev = jp_latch;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (jp_latch && !prev) begin
                found = 1'b1;
                break;
            end
            prev = jp_latch;
        end
        check("poll_seen", {31'h0, found}, 32'd1);
        repeat (80) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, p, per;
        logic [7:0] seq1 [10];
        seq1 = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};

        repeat (3) @(negedge clk);
        check("rst_latch", {31'h0, jp_latch}, 32'd0);
        check("rst_clk", {31'h0, jp_clk}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("latch_rise", {31'h0, jp_latch}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_latch", {31'h0, jp_latch}, 32'd0);
        check("rst_async_clk", {31'h0, jp_clk}, 32'd0);
        bus_read(16'h4016, 8'h00, 1, "rst_read");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("latch_rise2", {31'h0, jp_latch}, 32'd1);
        measure_poll(w, p, per);
        check("latch_width", w, 32'd8);
        check("clk_pulses", p, 32'd7);
        check("poll_period", per, 32'd200);

        bus_write(16'h4016, 8'h01);
        bus_write(16'h4016, 8'h00);
        for (int i = 0; i < 10; i++)
            bus_read(16'h4016, seq1[i], 1, $sformatf("seq_read%0d", i));

`ifdef JP_PAD2_EN
        bus_read(16'h4017, 8'h00, 3, "p2_multi");
        for (int i = 1; i < 7; i++)
            bus_read(16'h4017, 8'h00, 1, $sformatf("p2_read%0d", i));
        bus_read(16'h4017, 8'h01, 1, "p2_read8");
`else
        bus_read(16'h4017, 8'h00, 3, "p2_off");
`endif

        bus_write(16'h4016, 8'h01);
        for (int i = 0; i < 3; i++)
            bus_read(16'h4016, 8'h01, 1, "held_a");
        btn1 = 8'h08;
        wait_poll();
        bus_read(16'h4016, 8'h00, 1, "held_released");
        bus_write(16'h4016, 8'h00);

        for (int i = 0; i < 3; i++)
            bus_read(16'h4016, 8'h00, 1, "dec_pre");
        bus_write(16'h4017, 8'h01);
        bus_read(16'h4015, 8'h00, 1, "dec_4015");
        bus_read(16'h4018, 8'h00, 1, "dec_4018");
        bus_read(16'h4016, 8'h01, 1, "dec_shift1");

        repeat (2) @(posedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
